// File: rtl/mem_access_stage.sv
// Pipeline MEM stage: EXE/MEM and MEM/WB registers plus a req/ack data-bus master
// with byte lanes, misalignment detection and a request timeout.
module mem_access_stage #(
    parameter int TIMEOUT = 16,
    parameter int CNT_W   = 5
) (
    input  logic        clk,
    input  logic        clrn,
    input  logic [31:0] ealu,
    input  logic [31:0] eb,
    input  logic [4:0]  ern,
    input  logic        ewreg,
    input  logic        em2reg,
    input  logic        ewmem,
    input  logic [1:0]  esize,
    input  logic        esext,
    output logic        stall,
    output logic        d_req,
    output logic        d_wr,
    output logic [31:0] d_addr,
    output logic [3:0]  d_be,
    output logic [31:0] d_wdata,
    input  logic [31:0] d_rdata,
    input  logic        d_ack,
    output logic        wwreg,
    output logic        wm2reg,
    output logic [4:0]  wrn,
    output logic [31:0] walu,
    output logic [31:0] wmo,
    output logic        mem_err,
    output logic [31:0] err_addr
);

    localparam logic S_IDLE = 1'b0;
    localparam logic S_WAIT = 1'b1;

    logic [31:0] malu_q, malu_d, mb_q, mb_d;
    logic [4:0]  mrn_q, mrn_d;
    logic        mwreg_q, mwreg_d, mm2reg_q, mm2reg_d, mwmem_q, mwmem_d;
    logic [1:0]  msize_q, msize_d;
    logic        msext_q, msext_d;

    logic             state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic        wwreg_q, wwreg_d, wm2reg_q, wm2reg_d;
    logic [4:0]  wrn_q, wrn_d;
    logic [31:0] walu_q, walu_d, wmo_q, wmo_d;
    logic        mem_err_q, mem_err_d;
    logic [31:0] err_addr_q, err_addr_d;

    logic        m_mem, is_byte, is_half, is_word, misalign, req, abort, fault;
    logic [31:0] lane, ld_data;

    always_comb begin
        m_mem    = mm2reg_q | mwmem_q;
        is_byte  = (msize_q == 2'b10);
        is_half  = (msize_q == 2'b01);
        is_word  = ~is_byte & ~is_half;
        misalign = m_mem & ((is_half & malu_q[0]) | (is_word & (malu_q[1:0] != 2'b00)));
        req      = m_mem & ~misalign;
        // cnt holds the number of request cycles already spent, so the
        // current cycle is request number cnt+1.
        abort    = req & (state_q == S_WAIT) & (cnt_q == CNT_W'(TIMEOUT - 1)) & ~d_ack;
        fault    = misalign | abort;
        stall    = req & ~d_ack & ~abort;
    end

    always_comb begin
        d_req  = req;
        d_wr   = mwmem_q;
        d_addr = {malu_q[31:2], 2'b00};
        if (is_byte) begin
            d_be    = 4'b0001 << malu_q[1:0];
            d_wdata = {4{mb_q[7:0]}};
        end else if (is_half) begin
            d_be    = malu_q[1] ? 4'b1100 : 4'b0011;
            d_wdata = {2{mb_q[15:0]}};
        end else begin
            d_be    = 4'b1111;
            d_wdata = mb_q;
        end
    end

    always_comb begin
        lane = d_rdata >> {malu_q[1:0], 3'b000};
        if (is_byte)
            ld_data = {{24{msext_q & lane[7]}}, lane[7:0]};
        else if (is_half)
            ld_data = {{16{msext_q & lane[15]}}, lane[15:0]};
        else
            ld_data = d_rdata;
    end

    always_comb begin
        malu_d   = stall ? malu_q   : ealu;
        mb_d     = stall ? mb_q     : eb;
        mrn_d    = stall ? mrn_q    : ern;
        mwreg_d  = stall ? mwreg_q  : ewreg;
        mm2reg_d = stall ? mm2reg_q : em2reg;
        mwmem_d  = stall ? mwmem_q  : ewmem;
        msize_d  = stall ? msize_q  : esize;
        msext_d  = stall ? msext_q  : esext;
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            S_IDLE: begin
                if (req & ~d_ack) begin
                    state_d = S_WAIT;
                    cnt_d   = CNT_W'(1);
                end
            end
            default: begin
                if (d_ack | abort | ~req) begin
                    state_d = S_IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
        endcase
    end

    always_comb begin
        wwreg_d    = 1'b0;
        wm2reg_d   = 1'b0;
        wrn_d      = '0;
        walu_d     = '0;
        wmo_d      = '0;
        if (!stall) begin
            wwreg_d  = mwreg_q & ~fault;
            wm2reg_d = mm2reg_q & ~fault;
            wrn_d    = mrn_q;
            walu_d   = malu_q;
            wmo_d    = mm2reg_q ? ld_data : 32'b0;
        end
        mem_err_d  = fault;
        err_addr_d = fault ? malu_q : err_addr_q;
    end

    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            malu_q     <= '0;
            mb_q       <= '0;
            mrn_q      <= '0;
            mwreg_q    <= 1'b0;
            mm2reg_q   <= 1'b0;
            mwmem_q    <= 1'b0;
            msize_q    <= '0;
            msext_q    <= 1'b0;
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            wwreg_q    <= 1'b0;
            wm2reg_q   <= 1'b0;
            wrn_q      <= '0;
            walu_q     <= '0;
            wmo_q      <= '0;
            mem_err_q  <= 1'b0;
            err_addr_q <= '0;
        end else begin
            malu_q     <= malu_d;
            mb_q       <= mb_d;
            mrn_q      <= mrn_d;
            mwreg_q    <= mwreg_d;
            mm2reg_q   <= mm2reg_d;
            mwmem_q    <= mwmem_d;
            msize_q    <= msize_d;
            msext_q    <= msext_d;
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            wwreg_q    <= wwreg_d;
            wm2reg_q   <= wm2reg_d;
            wrn_q      <= wrn_d;
            walu_q     <= walu_d;
            wmo_q      <= wmo_d;
            mem_err_q  <= mem_err_d;
            err_addr_q <= err_addr_d;
        end
    end

    assign wwreg    = wwreg_q;
    assign wm2reg   = wm2reg_q;
    assign wrn      = wrn_q;
    assign walu     = walu_q;
    assign wmo      = wmo_q;
    assign mem_err  = mem_err_q;
    assign err_addr = err_addr_q;

endmodule

// File: tb/tb_mem_access_stage.sv
// Directed bench for mem_access_stage: ALU pass-through, loads, stores,
// misalignment, timeout with back-to-back access, and mid-access reset.
module tb_mem_access_stage;

    logic        clk = 1'b0;
    logic        clrn;
    logic [31:0] ealu, eb;
    logic [4:0]  ern;
    logic        ewreg, em2reg, ewmem;
    logic [1:0]  esize;
    logic        esext;
    logic        stall, d_req, d_wr;
    logic [31:0] d_addr;
    logic [3:0]  d_be;
    logic [31:0] d_wdata;
    logic [31:0] d_rdata;
    logic        d_ack;
    logic        wwreg, wm2reg;
    logic [4:0]  wrn;
    logic [31:0] walu, wmo;
    logic        mem_err;
    logic [31:0] err_addr;

    int total = 0;
    int bad   = 0;

    mem_access_stage #(.TIMEOUT(16), .CNT_W(5)) dut (
        .clk(clk), .clrn(clrn),
        .ealu(ealu), .eb(eb), .ern(ern),
        .ewreg(ewreg), .em2reg(em2reg), .ewmem(ewmem),
        .esize(esize), .esext(esext),
        .stall(stall), .d_req(d_req), .d_wr(d_wr), .d_addr(d_addr),
        .d_be(d_be), .d_wdata(d_wdata), .d_rdata(d_rdata), .d_ack(d_ack),
        .wwreg(wwreg), .wm2reg(wm2reg), .wrn(wrn), .walu(walu), .wmo(wmo),
        .mem_err(mem_err), .err_addr(err_addr)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic set_e(input logic [31:0] alu, input logic [31:0] b, input logic [4:0] rn,
                         input logic wreg, input logic m2reg, input logic wmem,
                         input logic [1:0] size, input logic sext);
        ealu = alu; eb = b; ern = rn;
        ewreg = wreg; em2reg = m2reg; ewmem = wmem;
        esize = size; esext = sext;
    endtask

    task automatic set_nop();
        set_e(32'h0, 32'h0, 5'd0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0);
    endtask

    // Present one op at E, let it enter M, then put a NOP behind it.
    task automatic issue(input logic [31:0] alu, input logic [31:0] b, input logic [4:0] rn,
                         input logic wreg, input logic m2reg, input logic wmem,
                         input logic [1:0] size, input logic sext);
        @(negedge clk);
        set_e(alu, b, rn, wreg, m2reg, wmem, size, sext);
        @(posedge clk); #1;
        set_nop();
    endtask

    // Run the op in M until it leaves (stall low at an edge); ack in cycle ack_cycle.
    task automatic run_access(input int ack_cycle, input logic [31:0] rdata,
                              output int stalls, output int reqs, output int unstable,
                              output logic [3:0] be0, output logic wr0,
                              output logic [31:0] wd0, output logic [31:0] addr0);
        logic done, st;
        stalls = 0; reqs = 0; unstable = 0; done = 1'b0;
        be0 = 4'h0; wr0 = 1'b0; wd0 = 32'h0; addr0 = 32'h0;
        for (int c = 1; c <= 40 && !done; c++) begin
            @(negedge clk);
            d_ack   = (c == ack_cycle);
            d_rdata = rdata;
            #1;
            if (d_req) begin
                if (reqs == 0) begin
                    be0 = d_be; wr0 = d_wr; wd0 = d_wdata; addr0 = d_addr;
                end else if (d_be !== be0 || d_wr !== wr0 || d_wdata !== wd0 || d_addr !== addr0) begin
                    unstable++;
                end
                reqs++;
            end
            st = stall;
            if (st) stalls++;
            @(posedge clk); #1;
            d_ack = 1'b0;
            if (!st) done = 1'b1;
        end
        chk("access_done", {31'b0, done}, 32'd1);
    endtask

    int          stalls, reqs, unstable;
    logic [3:0]  be0;
    logic        wr0;
    logic [31:0] wd0, addr0;

    initial begin
        clrn = 1'b0;
        set_nop();
        d_rdata = 32'h0;
        d_ack   = 1'b0;
        #12;
        chk("rst_stall",    {31'b0, stall},   32'd0);
        chk("rst_d_req",    {31'b0, d_req},   32'd0);
        chk("rst_d_wr",     {31'b0, d_wr},    32'd0);
        chk("rst_d_be",     {28'b0, d_be},    32'hf);
        chk("rst_wwreg",    {31'b0, wwreg},   32'd0);
        chk("rst_mem_err",  {31'b0, mem_err}, 32'd0);
        chk("rst_err_addr", err_addr,         32'h0);
        chk("rst_walu",     walu,             32'h0);
        @(negedge clk);
        clrn = 1'b1;

        // ALU op; an ack with no request must be ignored
        issue(32'h1234, 32'h0, 5'd5, 1'b1, 1'b0, 1'b0, 2'b00, 1'b0);
        run_access(1, 32'hdead_beef, stalls, reqs, unstable, be0, wr0, wd0, addr0);
        chk("alu_stalls", stalls, 0);
        chk("alu_reqs",   reqs,   0);
        chk("alu_walu",   walu,   32'h1234);
        chk("alu_wrn",    {27'b0, wrn},    32'd5);
        chk("alu_wwreg",  {31'b0, wwreg},  32'd1);
        chk("alu_wm2reg", {31'b0, wm2reg}, 32'd0);

        // Byte load, sign-extended, acked in 3rd request cycle
        issue(32'h103, 32'h0, 5'd7, 1'b1, 1'b1, 1'b0, 2'b10, 1'b1);
        run_access(3, 32'h80ff_ff00, stalls, reqs, unstable, be0, wr0, wd0, addr0);
        chk("lbs_stalls",   stalls, 2);
        chk("lbs_reqs",     reqs,   3);
        chk("lbs_unstable", unstable, 0);
        chk("lbs_be",       {28'b0, be0}, 32'h8);
        chk("lbs_addr",     addr0, 32'h100);
        chk("lbs_wr",       {31'b0, wr0}, 32'd0);
        chk("lbs_wmo",      wmo,   32'hffff_ff80);
        chk("lbs_wwreg",    {31'b0, wwreg},  32'd1);
        chk("lbs_wm2reg",   {31'b0, wm2reg}, 32'd1);
        chk("lbs_wrn",      {27'b0, wrn},    32'd7);

        // Same load, zero-extended
        issue(32'h103, 32'h0, 5'd7, 1'b1, 1'b1, 1'b0, 2'b10, 1'b0);
        run_access(3, 32'h80ff_ff00, stalls, reqs, unstable, be0, wr0, wd0, addr0);
        chk("lbu_wmo", wmo, 32'h0000_0080);

        // Half store, immediate ack
        issue(32'h202, 32'haaaa_beef, 5'd3, 1'b0, 1'b0, 1'b1, 2'b01, 1'b0);
        run_access(1, 32'h0, stalls, reqs, unstable, be0, wr0, wd0, addr0);
        chk("sh_stalls", stalls, 0);
        chk("sh_reqs",   reqs,   1);
        chk("sh_wr",     {31'b0, wr0}, 32'd1);
        chk("sh_be",     {28'b0, be0}, 32'hc);
        chk("sh_wdata",  wd0,   32'hbeef_beef);
        chk("sh_addr",   addr0, 32'h200);
        chk("sh_wwreg",  {31'b0, wwreg}, 32'd0);

        // Misaligned word load
        issue(32'h105, 32'h0, 5'd8, 1'b1, 1'b1, 1'b0, 2'b00, 1'b0);
        run_access(1, 32'h1111_1111, stalls, reqs, unstable, be0, wr0, wd0, addr0);
        chk("mis_reqs",     reqs,   0);
        chk("mis_stalls",   stalls, 0);
        chk("mis_mem_err",  {31'b0, mem_err}, 32'd1);
        chk("mis_err_addr", err_addr, 32'h105);
        chk("mis_wwreg",    {31'b0, wwreg},  32'd0);
        chk("mis_wm2reg",   {31'b0, wm2reg}, 32'd0);
        @(posedge clk); #1;
        chk("mis_pulse_end", {31'b0, mem_err}, 32'd0);

        // Timeout, with a load queued right behind it
        issue(32'h300, 32'h0, 5'd9, 1'b1, 1'b1, 1'b0, 2'b00, 1'b0);
        set_e(32'h400, 32'h0, 5'd10, 1'b1, 1'b1, 1'b0, 2'b00, 1'b0);
        run_access(0, 32'h0, stalls, reqs, unstable, be0, wr0, wd0, addr0);
        chk("to_reqs",     reqs,   16);
        chk("to_stalls",   stalls, 15);
        chk("to_mem_err",  {31'b0, mem_err}, 32'd1);
        chk("to_err_addr", err_addr, 32'h300);
        chk("to_wwreg",    {31'b0, wwreg}, 32'd0);
        set_nop();
        run_access(1, 32'h1234_5678, stalls, reqs, unstable, be0, wr0, wd0, addr0);
        chk("b2b_reqs",     reqs,   1);
        chk("b2b_stalls",   stalls, 0);
        chk("b2b_addr",     addr0,  32'h400);
        chk("b2b_wmo",      wmo,    32'h1234_5678);
        chk("b2b_wwreg",    {31'b0, wwreg}, 32'd1);
        chk("b2b_wrn",      {27'b0, wrn},   32'd10);
        chk("b2b_mem_err",  {31'b0, mem_err}, 32'd0);
        chk("b2b_err_addr", err_addr, 32'h300);

        // Reset during WAIT
        issue(32'h500, 32'h0, 5'd11, 1'b1, 1'b1, 1'b0, 2'b00, 1'b0);
        @(negedge clk); d_ack = 1'b0; #1;
        chk("rw_stall1", {31'b0, stall}, 32'd1);
        @(posedge clk);
        @(negedge clk); #1;
        chk("rw_req_wait", {31'b0, d_req}, 32'd1);
        clrn = 1'b0;
        #1;
        chk("rw_d_req",    {31'b0, d_req},   32'd0);
        chk("rw_stall",    {31'b0, stall},   32'd0);
        chk("rw_walu",     walu,             32'h0);
        chk("rw_wmo",      wmo,              32'h0);
        chk("rw_wwreg",    {31'b0, wwreg},   32'd0);
        chk("rw_err_addr", err_addr,         32'h0);
        @(posedge clk); #1;
        @(negedge clk);
        clrn = 1'b1;
        issue(32'h602, 32'h0, 5'd12, 1'b1, 1'b1, 1'b0, 2'b01, 1'b1);
        run_access(2, 32'h8001_0000, stalls, reqs, unstable, be0, wr0, wd0, addr0);
        chk("pr_reqs",   reqs,   2);
        chk("pr_stalls", stalls, 1);
        chk("pr_be",     {28'b0, be0}, 32'hc);
        chk("pr_wmo",    wmo,    32'hffff_8001);
        chk("pr_wwreg",  {31'b0, wwreg}, 32'd1);
        chk("pr_wrn",    {27'b0, wrn},   32'd12);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
